// File: rtl/hazard_pipe_regs_pkg.sv
// Shared types and constants for the RV32I pipeline-register bank.
// Stage payload structs travel between the F/D/E/M/W registers.
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
    } ctrl_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] Rs1;
        logic [REG_IDX_W-1:0] Rs2;
        logic [REG_IDX_W-1:0] Rd;
    } ids_t;

    localparam ctrl_t CTRL_BUBBLE = '{RegWrite: 1'b0, ResultSrc: 2'b00, MemWrite: 1'b0};
    localparam ids_t  IDS_BUBBLE  = '{Rs1: 5'd0, Rs2: 5'd0, Rd: 5'd0};

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    typedef struct packed {
        ids_t            ids;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic            valid;
    } idex_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        ctrl_t                ctrl;
        logic                 valid;
    } exmem_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 RegWrite;
        logic [1:0]           ResultSrc;
        logic                 valid;
    } memwb_t;

    localparam idex_t IDEX_BUBBLE = '{ids: IDS_BUBBLE, ctrl: CTRL_BUBBLE, pc: 32'd0, valid: 1'b0};
    localparam exmem_t EXMEM_RESET = '{rd: 5'd0, ctrl: CTRL_BUBBLE, valid: 1'b0};
    localparam memwb_t MEMWB_RESET = '{rd: 5'd0, RegWrite: 1'b0, ResultSrc: 2'b00, valid: 1'b0};

endpackage

// File: rtl/hazard_pipe_regs_if.sv
// Hazard-control and pipeline-field bundle of hazard_pipe_regs.
// HAZARD_PERF_CNT_EN adds the CNT_W parameter and the perf-counter outputs.
interface hazard_pipe_regs_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;

    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [31:0] PCNextF;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        MemWriteD;

    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE0;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        ValidD;
    logic        ValidE;
    logic        ValidM;
    logic        ValidW;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;
    logic [CNT_W-1:0] RetireCnt;
`endif

    // Hazard unit / fetch / decode side
    modport master (
        output StallF, StallD, FlushD, FlushE,
        output PCNextF, InstrF, PCPlus4F,
        output RegWriteD, ResultSrcD, MemWriteD,
        input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
        input  Rs1E, Rs2E, RdE, PCE, RegWriteE, MemWriteE, ResultSrcE0,
        input  RdM, RegWriteM, MemWriteM, ResultSrcM,
        input  RdW, RegWriteW, ResultSrcW,
        input  ValidD, ValidE, ValidM, ValidW
`ifdef HAZARD_PERF_CNT_EN
        , input StallCnt, FlushCnt, RetireCnt
`endif
    );

    // Pipeline-register bank side
    modport slave (
        input  StallF, StallD, FlushD, FlushE,
        input  PCNextF, InstrF, PCPlus4F,
        input  RegWriteD, ResultSrcD, MemWriteD,
        output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
        output Rs1E, Rs2E, RdE, PCE, RegWriteE, MemWriteE, ResultSrcE0,
        output RdM, RegWriteM, MemWriteM, ResultSrcM,
        output RdW, RegWriteW, ResultSrcW,
        output ValidD, ValidE, ValidM, ValidW
`ifdef HAZARD_PERF_CNT_EN
        , output StallCnt, FlushCnt, RetireCnt
`endif
    );

endinterface

// File: rtl/hazard_pipe_regs_reg.sv
// Generic stage register: synchronous reset, clear-to-reset-value, hold when not enabled.
// Priority rst > clr > hold > load.
module pipe_reg_en_clr #(
    parameter int unsigned    W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_pipe_regs.sv
// PC/IF-ID/ID-EX/EX-MEM/MEM-WB register bank of the 5-stage RV32I core.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_pipe_regs #(
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
`ifdef HAZARD_PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    hazard_pipe_regs_if.slave bus
);
    import pipe_pkg::*;

    localparam int unsigned IFID_W  = $bits(ifid_t);
    localparam int unsigned IDEX_W  = $bits(idex_t);
    localparam int unsigned EXMEM_W = $bits(exmem_t);
    localparam int unsigned MEMWB_W = $bits(memwb_t);

    // A flushed IF/ID slot looks exactly like the reset slot: NOP, zero PCs, invalid.
    localparam ifid_t IFID_RESET = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

    logic [31:0] pc_f;
    ifid_t       ifid_d, ifid_q;
    idex_t       idex_d, idex_q;
    exmem_t      exmem_d, exmem_q;
    memwb_t      memwb_d, memwb_q;

    always_comb begin
        ifid_d          = IFID_RESET;
        ifid_d.instr    = bus.InstrF;
        ifid_d.pc       = pc_f;
        ifid_d.pc_plus4 = bus.PCPlus4F;
        ifid_d.valid    = 1'b1;
    end

    // Register indices come straight from the instruction fields held in IF/ID
    always_comb begin
        idex_d                = IDEX_BUBBLE;
        idex_d.ids.Rs1        = ifid_q.instr[19:15];
        idex_d.ids.Rs2        = ifid_q.instr[24:20];
        idex_d.ids.Rd         = ifid_q.instr[11:7];
        idex_d.ctrl.RegWrite  = bus.RegWriteD;
        idex_d.ctrl.ResultSrc = bus.ResultSrcD;
        idex_d.ctrl.MemWrite  = bus.MemWriteD;
        idex_d.pc             = ifid_q.pc;
        idex_d.valid          = ifid_q.valid;
    end

    always_comb begin
        exmem_d       = EXMEM_RESET;
        exmem_d.rd    = idex_q.ids.Rd;
        exmem_d.ctrl  = idex_q.ctrl;
        exmem_d.valid = idex_q.valid;
    end

    always_comb begin
        memwb_d           = MEMWB_RESET;
        memwb_d.rd        = exmem_q.rd;
        memwb_d.RegWrite  = exmem_q.ctrl.RegWrite;
        memwb_d.ResultSrc = exmem_q.ctrl.ResultSrc;
        memwb_d.valid     = exmem_q.valid;
    end

    pipe_reg_en_clr #(.W(32), .RST_VAL(RESET_PC)) u_pc_f (
        .clk (clk),
        .rst (rst),
        .en  (~bus.StallF),
        .clr (1'b0),
        .d   (bus.PCNextF),
        .q   (pc_f)
    );

    pipe_reg_en_clr #(.W(IFID_W), .RST_VAL(IFID_RESET)) u_ifid (
        .clk (clk),
        .rst (rst),
        .en  (~bus.StallD),
        .clr (bus.FlushD),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    // ID/EX never holds; a flush injects a bubble with no write enables
    pipe_reg_en_clr #(.W(IDEX_W), .RST_VAL(IDEX_BUBBLE)) u_idex (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (bus.FlushE),
        .d   (idex_d),
        .q   (idex_q)
    );

    pipe_reg_en_clr #(.W(EXMEM_W), .RST_VAL(EXMEM_RESET)) u_exmem (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (exmem_d),
        .q   (exmem_q)
    );

    pipe_reg_en_clr #(.W(MEMWB_W), .RST_VAL(MEMWB_RESET)) u_memwb (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (memwb_d),
        .q   (memwb_q)
    );

    assign bus.PCF      = pc_f;
    assign bus.InstrD   = ifid_q.instr;
    assign bus.PCD      = ifid_q.pc;
    assign bus.PCPlus4D = ifid_q.pc_plus4;
    assign bus.ValidD   = ifid_q.valid;
    assign bus.Rs1D     = ifid_q.instr[19:15];
    assign bus.Rs2D     = ifid_q.instr[24:20];
    assign bus.RdD      = ifid_q.instr[11:7];

    assign bus.Rs1E        = idex_q.ids.Rs1;
    assign bus.Rs2E        = idex_q.ids.Rs2;
    assign bus.RdE         = idex_q.ids.Rd;
    assign bus.PCE         = idex_q.pc;
    assign bus.RegWriteE   = idex_q.ctrl.RegWrite;
    assign bus.MemWriteE   = idex_q.ctrl.MemWrite;
    assign bus.ResultSrcE0 = idex_q.ctrl.ResultSrc[0];
    assign bus.ValidE      = idex_q.valid;

    assign bus.RdM        = exmem_q.rd;
    assign bus.RegWriteM  = exmem_q.ctrl.RegWrite;
    assign bus.MemWriteM  = exmem_q.ctrl.MemWrite;
    assign bus.ResultSrcM = exmem_q.ctrl.ResultSrc;
    assign bus.ValidM     = exmem_q.valid;

    assign bus.RdW        = memwb_q.rd;
    assign bus.RegWriteW  = memwb_q.RegWrite;
    assign bus.ResultSrcW = memwb_q.ResultSrc;
    assign bus.ValidW     = memwb_q.valid;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    // A load-use stall also raises FlushE; count it only as a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (bus.StallD) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.FlushE && !bus.StallD) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (memwb_q.valid) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.StallCnt  = stall_cnt;
    assign bus.FlushCnt  = flush_cnt;
    assign bus.RetireCnt = retire_cnt;
`endif

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Self-checking bench for hazard_pipe_regs: directed hazard scenarios plus random traffic
// compared every cycle against an instruction-slot model of the pipeline.
module tb_hazard_pipe_regs;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = 32'h0000_2283;
    localparam logic [31:0] ADD_X6  = 32'h0002_8333;
`ifdef HAZARD_PERF_CNT_EN
    localparam int unsigned TB_CNT_W = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    hazard_pipe_regs_if #(.CNT_W(TB_CNT_W)) bus ();
    hazard_pipe_regs #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(TB_CNT_W)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
`else
    hazard_pipe_regs_if bus ();
    hazard_pipe_regs #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
`endif

    // One instruction slot as it travels E -> M -> W
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw;
        logic [1:0]  rsrc;
        logic [31:0] pc;
        logic        valid;
    } slot_t;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d;
    logic        m_valid_d;
    slot_t       st [3];
`ifdef HAZARD_PERF_CNT_EN
    int unsigned m_stall, m_flush, m_retire;
`endif

    function automatic slot_t bubble();
        slot_t s;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.rw = 0; s.mw = 0; s.rsrc = 0; s.pc = 0; s.valid = 0;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge
    task automatic model_step();
        slot_t e;
        if (rst) begin
            m_pc = 32'h0; m_instr_d = NOP; m_pc_d = 0; m_pc4_d = 0; m_valid_d = 0;
            for (int i = 0; i < 3; i++) st[i] = bubble();
`ifdef HAZARD_PERF_CNT_EN
            m_stall = 0; m_flush = 0; m_retire = 0;
`endif
            return;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (bus.StallD) m_stall = (m_stall + 1) % (1 << TB_CNT_W);
        if (bus.FlushE && !bus.StallD) m_flush = (m_flush + 1) % (1 << TB_CNT_W);
        if (st[2].valid) m_retire = (m_retire + 1) % (1 << TB_CNT_W);
`endif
        if (bus.FlushE) begin
            e = bubble();
        end else begin
            e.rs1 = m_instr_d[19:15]; e.rs2 = m_instr_d[24:20]; e.rd = m_instr_d[11:7];
            e.rw = bus.RegWriteD; e.mw = bus.MemWriteD; e.rsrc = bus.ResultSrcD;
            e.pc = m_pc_d; e.valid = m_valid_d;
        end
        st[2] = st[1];
        st[1] = st[0];
        st[0] = e;
        if (bus.FlushD) begin
            m_instr_d = NOP; m_pc_d = 0; m_pc4_d = 0; m_valid_d = 0;
        end else if (!bus.StallD) begin
            m_instr_d = bus.InstrF; m_pc_d = m_pc; m_pc4_d = bus.PCPlus4F; m_valid_d = 1;
        end
        if (!bus.StallF) m_pc = bus.PCNextF;
    endtask

    task automatic check_model();
        chk("PCF", bus.PCF, m_pc);
        chk("InstrD", bus.InstrD, m_instr_d);
        chk("PCD", bus.PCD, m_pc_d);
        chk("PCPlus4D", bus.PCPlus4D, m_pc4_d);
        chk("ValidD", 32'(bus.ValidD), 32'(m_valid_d));
        chk("Rs1D", 32'(bus.Rs1D), 32'((m_instr_d >> 15) & 32'h1f));
        chk("Rs2D", 32'(bus.Rs2D), 32'((m_instr_d >> 20) & 32'h1f));
        chk("RdD", 32'(bus.RdD), 32'((m_instr_d >> 7) & 32'h1f));
        chk("Rs1E", 32'(bus.Rs1E), 32'(st[0].rs1));
        chk("Rs2E", 32'(bus.Rs2E), 32'(st[0].rs2));
        chk("RdE", 32'(bus.RdE), 32'(st[0].rd));
        chk("PCE", bus.PCE, st[0].pc);
        chk("RegWriteE", 32'(bus.RegWriteE), 32'(st[0].rw));
        chk("MemWriteE", 32'(bus.MemWriteE), 32'(st[0].mw));
        chk("ResultSrcE0", 32'(bus.ResultSrcE0), 32'(st[0].rsrc % 2));
        chk("ValidE", 32'(bus.ValidE), 32'(st[0].valid));
        chk("RdM", 32'(bus.RdM), 32'(st[1].rd));
        chk("RegWriteM", 32'(bus.RegWriteM), 32'(st[1].rw));
        chk("MemWriteM", 32'(bus.MemWriteM), 32'(st[1].mw));
        chk("ResultSrcM", 32'(bus.ResultSrcM), 32'(st[1].rsrc));
        chk("ValidM", 32'(bus.ValidM), 32'(st[1].valid));
        chk("RdW", 32'(bus.RdW), 32'(st[2].rd));
        chk("RegWriteW", 32'(bus.RegWriteW), 32'(st[2].rw));
        chk("ResultSrcW", 32'(bus.ResultSrcW), 32'(st[2].rsrc));
        chk("ValidW", 32'(bus.ValidW), 32'(st[2].valid));
`ifdef HAZARD_PERF_CNT_EN
        chk("StallCnt", 32'(bus.StallCnt), m_stall);
        chk("FlushCnt", 32'(bus.FlushCnt), m_flush);
        chk("RetireCnt", 32'(bus.RetireCnt), m_retire);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic no_hazard();
        bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0;
    endtask

    task automatic fetch(input logic [31:0] instr);
        bus.InstrF   = instr;
        bus.PCNextF  = m_pc + 32'd4;
        bus.PCPlus4F = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    logic [31:0] pc_saved;

    initial begin
        no_hazard();
        bus.PCNextF = 0; bus.InstrF = 0; bus.PCPlus4F = 0;
        bus.RegWriteD = 0; bus.ResultSrcD = 0; bus.MemWriteD = 0;

        // Reset held three cycles while the hazard controls toggle
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            bus.StallF = i[0]; bus.StallD = 1'b1; bus.FlushD = ~i[0]; bus.FlushE = i[0];
            bus.PCNextF = 32'hdead_0000 + 32'(i); bus.InstrF = 32'hffff_ffff;
            cycle();
        end
        chk("rst_PCF", bus.PCF, 32'h0);
        chk("rst_InstrD", bus.InstrD, 32'h0000_0013);
        chk("rst_valids", {28'd0, bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW}, 32'h0);
        chk("rst_rds", {17'd0, bus.RdE, bus.RdM, bus.RdW}, 32'h0);
        rst = 0;
        no_hazard();

        // Four back-to-back instructions with rd = 1..4
        bus.RegWriteD = 1;
        for (int k = 0; k < 6; k++) begin
            fetch(k < 4 ? mk_r(5'(k + 1), 5'(k + 10), 5'(k + 20)) : NOP);
            cycle();
            if (k == 0) chk("stream_RdD", 32'(bus.RdD), 32'd1);
            if (k == 1) chk("stream_RdE", 32'(bus.RdE), 32'd1);
            if (k == 2) chk("stream_RdM", 32'(bus.RdM), 32'd1);
            if (k == 3) begin
                chk("stream_RdW", 32'(bus.RdW), 32'd1);
                chk("stream_ValidW", 32'(bus.ValidW), 32'd1);
            end
            if (k == 4) chk("stream_RdW2", 32'(bus.RdW), 32'd2);
        end

        // Load x5 then dependent add: one load-use stall cycle
        bus.RegWriteD = 0;
        fetch(LW_X5);
        cycle();
        bus.RegWriteD = 1; bus.ResultSrcD = 2'b01;
        fetch(ADD_X6);
        cycle();
        chk("lu_RdE", 32'(bus.RdE), 32'd5);
        chk("lu_ResultSrcE0", 32'(bus.ResultSrcE0), 32'd1);
        pc_saved = m_pc;
        bus.ResultSrcD = 2'b00;
        fetch(NOP);
        bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
        cycle();
        chk("lu_InstrD", bus.InstrD, ADD_X6);
        chk("lu_PCF", bus.PCF, pc_saved);
        chk("lu_ValidE", 32'(bus.ValidE), 32'd0);
        chk("lu_RegWriteE", 32'(bus.RegWriteE), 32'd0);
        chk("lu_RdM", 32'(bus.RdM), 32'd5);
        no_hazard();
        cycle();
        chk("lu_add_RdE", 32'(bus.RdE), 32'd6);

        // Taken branch to 0x100
        bus.StallF = 0; bus.StallD = 0; bus.FlushD = 1; bus.FlushE = 1;
        bus.InstrF = mk_r(5'd7, 5'd1, 5'd2); bus.PCNextF = 32'h100;
        cycle();
        chk("br_InstrD", bus.InstrD, 32'h0000_0013);
        chk("br_ValidD", 32'(bus.ValidD), 32'd0);
        chk("br_ValidE", 32'(bus.ValidE), 32'd0);
        chk("br_PCF", bus.PCF, 32'h100);

        // Flush and stall together: flush wins
        no_hazard();
        fetch(mk_r(5'd9, 5'd3, 5'd4));
        cycle();
        bus.FlushD = 1; bus.StallD = 1; bus.StallF = 1;
        cycle();
        chk("fs_InstrD", bus.InstrD, 32'h0000_0013);
        chk("fs_ValidD", 32'(bus.ValidD), 32'd0);
        no_hazard();

        // Random traffic, including mid-stall resets
        for (int c = 0; c < 1500; c++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            no_hazard();
            rst = ($urandom_range(0, 59) == 0);
            if (sel < 12) begin
                bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
            end else if (sel < 22) begin
                bus.FlushD = 1; bus.FlushE = 1;
            end else if (sel < 32) begin
                bus.StallF = 1'($urandom); bus.StallD = 1'($urandom);
                bus.FlushD = 1'($urandom); bus.FlushE = 1'($urandom);
            end
            bus.InstrF     = $urandom;
            bus.PCNextF    = $urandom;
            bus.PCPlus4F   = $urandom;
            bus.RegWriteD  = 1'($urandom);
            bus.MemWriteD  = 1'($urandom);
            bus.ResultSrcD = 2'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Pipeline-register bank for the 5-stage RV32I core.
- Consumes the hazard controls StallF, StallD, FlushD and FlushE.
- Produces the register-index and control fields that hazard detection and forwarding read: Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW, RegWriteM/W and ResultSrcE0.
- Holds PC (F), IF/ID, ID/EX control, EX/MEM control and MEM/WB control state, plus per-stage valid bits.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on IF/ID flush or reset (addi x0,x0,0).
- CNT_W, 32, perf-counter width (used only with PERF_CNT_EN).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID
- FlushD  in  1  clear IF/ID to NOP
- FlushE  in  1  clear ID/EX to bubble
- PCNextF  in  32  next PC
- InstrF  in  32  fetched instruction
- PCPlus4F  in  32  PCF+4
- RegWriteD  in  1  decode control
- ResultSrcD  in  2  decode control
- MemWriteD  in  1  decode control
- PCF  out  32  fetch PC
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID contents
- Rs1D, Rs2D, RdD  out  5 each  InstrD[19:15], InstrD[24:20], InstrD[11:7] (combinational)
- Rs1E, Rs2E, RdE, PCE  out  5,5,5,32  ID/EX fields
- RegWriteE, MemWriteE  out  1 each
- ResultSrcE0  out  1  ResultSrcE[0]
- RdM, RegWriteM, MemWriteM  out  5,1,1
- ResultSrcM  out  2
- RdW, RegWriteW  out  5,1
- ResultSrcW  out  2
- ValidD, ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction

Behaviour:
- All state updates on posedge clk. Outputs are registered except Rs1D/Rs2D/RdD and ResultSrcE0.
- Reset (rst=1 at an edge):
  - PCF=RESET_PC, InstrD=NOP_INSTR.
  - PCD=PCPlus4D=PCE=0.
  - All Rs/Rd fields, RegWrite*, MemWrite*, ResultSrc* = 0.
  - All Valid* = 0.
  - rst overrides every stall/flush input. Reset mid-stall discards the held instruction.
- F stage:
  - StallF=1: PCF holds.
  - Otherwise: PCF<=PCNextF.
- IF/ID:
  - FlushD has priority over StallD. On flush: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - Else if StallD: hold all fields.
  - Else: load InstrF/PCF/PCPlus4F and set ValidD<=1.
- ID/EX:
  - Never stalls.
  - FlushE=1: load bubble. Rs1E=Rs2E=RdE=0, RegWriteE=MemWriteE=0, ResultSrcE=0, PCE=0, ValidE=0.
  - Else: load the D fields. ValidE<=ValidD.
- EX/MEM and MEM/WB:
  - Free-running: copy the previous stage every cycle, including the valid bit.
- Load-use stall (StallF=StallD=FlushE=1):
  - PC and IF/ID hold.
  - One bubble enters E.
  - The load proceeds to M.
- Branch taken (FlushD=FlushE=1):
  - The two younger instructions become bubbles.
  - PCF takes the target through PCNextF.
- Simultaneous FlushD and StallD: flush wins.
- Simultaneous StallF and FlushD: PCF holds, IF/ID still flushes.
- A bubble never asserts RegWrite or MemWrite, so it cannot create a forward or a store.
- Rd=0 passes through unchanged. x0 filtering is done by the consumer.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt, FlushCnt, RetireCnt, each CNT_W wide.
  - StallCnt increments on cycles with StallD=1.
  - FlushCnt increments on cycles with FlushE=1 and StallD=0 (so a load-use stall is not counted twice).
  - RetireCnt increments on cycles with ValidW=1.
  - All counters reset to 0 and wrap modulo 2^CNT_W.
  - Counting is suspended while rst=1.
- Undefined: no counters, ports absent, zero added logic.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INSTR and the RESET_PC default.
  - Struct ctrl_t {RegWrite, ResultSrc[1:0], MemWrite}.
  - Struct ids_t {Rs1, Rs2, Rd}.
  - Constant bubble values CTRL_BUBBLE and IDS_BUBBLE.
- Sub-module pipe_reg_en_clr: parameterized width, inputs clk, rst, en, clr, d, RST_VAL. Priority order is rst > clr > ~en(hold) > load. It is instantiated once per stage register.

Test Plan:
- Reset held 3 cycles with stall/flush toggling -> PCF=RESET_PC, InstrD=0x00000013, all Valid*=0, RdE=RdM=RdW=0.
- Stream 4 instructions, no hazards -> the RdD of instruction n appears on RdE/RdM/RdW at +1/+2/+3 cycles. ValidW=1 from cycle 4 onward.
- Load rd=x5 followed by add rs1=x5. Pulse StallF=StallD=FlushE=1 for one cycle -> PCF and InstrD hold, ValidE=0 and RegWriteE=0 the next cycle, load RdM=5.
- Taken branch: FlushD=FlushE=1 for one cycle with PCNextF=0x100 -> InstrD=NOP, ValidD=ValidE=0, PCF=0x100.
- FlushD=StallD=1 simultaneously -> InstrD=NOP_INSTR (flush wins).
- With HAZARD_PERF_CNT_EN: 2 load-use stalls, 1 branch flush, 10 retired instructions -> StallCnt=2, FlushCnt=1, RetireCnt=10.
- With HAZARD_PERF_CNT_EN and CNT_W=4: 17 retires -> RetireCnt wraps to 1.
